// File: rtl/control_pkg.sv
// control_pkg: opcode constants, ALUOp encodings and the per-stage control bundles.
package control_pkg;
  localparam int OP_R   = 0;
  localparam int OP_J   = 2;
  localparam int OP_JAL = 3;
  localparam int OP_BEQ = 4;
  localparam int OP_ORI = 13;
  localparam int OP_LW  = 35;
  localparam int OP_SW  = 43;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
  } ex_t;
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } mem_t;
  typedef struct packed {
    logic reg_write;
    logic memto_reg;
    logic link;
  } wb_t;
  typedef struct packed {
    ex_t  ex;
    mem_t m;
    wb_t  wb;
  } ctrl_t;
  typedef struct packed {
    mem_t m;
    wb_t  wb;
  } exmem_t;
endpackage

// File: rtl/control_decode.sv
// control_decode: combinational opcode-to-control decoder for the ID stage.
// JAL (opcode 3) decodes only when CTRL_JAL_EN is defined; otherwise it is illegal.
module control_decode
  import control_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] opcode_i,
  output ctrl_t           ctrl_o,
  output logic            illegal_o
);
  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_W'(OP_R): begin
        ctrl_o.ex.reg_dst   = 1'b1;
        ctrl_o.ex.alu_op    = ALU_FUNCT;
        ctrl_o.wb.reg_write = 1'b1;
      end
      OP_W'(OP_LW): begin
        ctrl_o.ex.alu_src   = 1'b1;
        ctrl_o.ex.alu_op    = ALU_ADD;
        ctrl_o.m.mem_read   = 1'b1;
        ctrl_o.wb.memto_reg = 1'b1;
        ctrl_o.wb.reg_write = 1'b1;
      end
      OP_W'(OP_SW): begin
        ctrl_o.ex.alu_src  = 1'b1;
        ctrl_o.ex.alu_op   = ALU_ADD;
        ctrl_o.m.mem_write = 1'b1;
      end
      OP_W'(OP_BEQ): begin
        ctrl_o.ex.alu_op = ALU_SUB;
        ctrl_o.m.branch  = 1'b1;
      end
      OP_W'(OP_J): ctrl_o.m.jump = 1'b1;
      OP_W'(OP_ORI): begin
        ctrl_o.ex.alu_src   = 1'b1;
        ctrl_o.ex.alu_op    = ALU_OR;
        ctrl_o.wb.reg_write = 1'b1;
      end
`ifdef CTRL_JAL_EN
      OP_W'(OP_JAL): begin
        ctrl_o.m.jump       = 1'b1;
        ctrl_o.wb.reg_write = 1'b1;
        ctrl_o.wb.link      = 1'b1;
      end
`endif
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/control_pipeline.sv
// control_pipeline: ID/EX, EX/MEM, MEM/WB control registers with load-use stall and flush.
// CTRL_JAL_EN enables the JAL decode; without it nothing ever sets the link bit, so wb_Link stays 0.
module control_pipeline
  import control_pkg::*;
#(
  parameter int OP_W       = 6,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OP_W-1:0]       opcode_id,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic                  flush,
  output logic                  ex_RegDst,
  output logic                  ex_ALUSrc,
  output logic [1:0]            ex_ALUOp,
  output logic                  mem_MemRead,
  output logic                  mem_MemWrite,
  output logic                  mem_Branch,
  output logic                  mem_Jump,
  output logic                  wb_RegWrite,
  output logic                  wb_MemtoReg,
  output logic                  wb_Link,
  output logic                  stall_id,
  output logic                  illegal_op
);
  ctrl_t                 dec, idex_d, idex_q;
  exmem_t                exmem_d, exmem_q;
  wb_t                   memwb_q;
  logic                  dec_ill, bubble;
  logic                  idex_v_q, exmem_v_q, memwb_v_q, ill_q;
  logic [REG_ADDR_W-1:0] ex_rt_q;

  control_decode #(.OP_W(OP_W)) u_decode (
    .opcode_i  (opcode_id),
    .ctrl_o    (dec),
    .illegal_o (dec_ill)
  );

  // Flush wins over a load-use hazard: the stalled instruction is squashed anyway.
  assign stall_id = idex_v_q & idex_q.m.mem_read & (ex_rt_q != '0) &
                    ((ex_rt_q == rs_id) | (ex_rt_q == rt_id)) & ~flush;
  assign bubble   = stall_id | flush;
  assign idex_d   = bubble ? '0 : dec;
  assign exmem_d  = flush ? '0 : {idex_q.m, idex_q.wb};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q    <= '0;
      exmem_q   <= '0;
      memwb_q   <= '0;
      idex_v_q  <= 1'b0;
      exmem_v_q <= 1'b0;
      memwb_v_q <= 1'b0;
      ill_q     <= 1'b0;
      ex_rt_q   <= '0;
    end else begin
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      memwb_q   <= exmem_q.wb;
      idex_v_q  <= ~bubble;
      exmem_v_q <= idex_v_q & ~flush;
      memwb_v_q <= exmem_v_q;
      ill_q     <= ~bubble & dec_ill;
      ex_rt_q   <= rt_id;
    end
  end

  assign ex_RegDst    = idex_v_q & idex_q.ex.reg_dst;
  assign ex_ALUSrc    = idex_v_q & idex_q.ex.alu_src;
  assign ex_ALUOp     = {2{idex_v_q}} & idex_q.ex.alu_op;
  assign mem_MemRead  = exmem_v_q & exmem_q.m.mem_read;
  assign mem_MemWrite = exmem_v_q & exmem_q.m.mem_write;
  assign mem_Branch   = exmem_v_q & exmem_q.m.branch;
  assign mem_Jump     = exmem_v_q & exmem_q.m.jump;
  assign wb_RegWrite  = memwb_v_q & memwb_q.reg_write;
  assign wb_MemtoReg  = memwb_v_q & memwb_q.memto_reg;
  assign wb_Link      = memwb_v_q & memwb_q.link;
  assign illegal_op   = ill_q;
endmodule

// File: tb/tb_control_pipeline.sv
// tb_control_pipeline: directed self-checking bench for control_pipeline.
module tb_control_pipeline;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode_id = '0;
  logic [4:0] rs_id = '0, rt_id = '0;
  logic       flush = 1'b0;
  logic       ex_RegDst, ex_ALUSrc, mem_MemRead, mem_MemWrite, mem_Branch, mem_Jump;
  logic       wb_RegWrite, wb_MemtoReg, wb_Link, stall_id, illegal_op;
  logic [1:0] ex_ALUOp;
  logic [3:0] ex_v, mem_v, wb_v;
  int         checks = 0, errors = 0;

  control_pipeline dut (
    .clk(clk), .rst(rst), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id), .flush(flush),
    .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_Branch(mem_Branch),
    .mem_Jump(mem_Jump), .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
    .wb_Link(wb_Link), .stall_id(stall_id), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign ex_v  = {ex_RegDst, ex_ALUSrc, ex_ALUOp};
  assign mem_v = {mem_MemRead, mem_MemWrite, mem_Branch, mem_Jump};
  assign wb_v  = {1'b0, wb_RegWrite, wb_MemtoReg, wb_Link};

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e, m, w, input logic s, i);
    chk({tag, ".ex"}, ex_v, e);
    chk({tag, ".mem"}, mem_v, m);
    chk({tag, ".wb"}, wb_v, w);
    chk({tag, ".stall"}, {3'b0, stall_id}, {3'b0, s});
    chk({tag, ".ill"}, {3'b0, illegal_op}, {3'b0, i});
  endtask

  // Drive the ID inputs just after a falling edge, then settle.
  task automatic step(input logic [5:0] op, input logic [4:0] rs, rt, input logic fl);
    @(negedge clk);
    opcode_id = op; rs_id = rs; rt_id = rt; flush = fl;
    #1;
  endtask

  initial begin
    @(negedge clk); #1;
    chk_all("in_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; opcode_id = 6'd0;
    #1;
    chk_all("post_release", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    // R stream
    step(6'd0, 5'd0, 5'd0, 1'b0);
    chk("r_c1.ex", ex_v, 4'b1010);
    chk("r_c1.wb", wb_v, 4'b0000);
    step(6'd0, 5'd0, 5'd0, 1'b0);
    chk("r_c2.mem", mem_v, 4'b0000);
    chk("r_c2.wb", wb_v, 4'b0000);
    step(6'd0, 5'd0, 5'd0, 1'b0);
    chk("r_c3.wb", wb_v, 4'b0100);
    // load-use hazard on r8
    step(6'd35, 5'd1, 5'd8, 1'b0);
    chk("lu_lw_id.stall", {3'b0, stall_id}, 4'b0000);
    step(6'd0, 5'd8, 5'd9, 1'b0);
    chk("lu_stall.stall", {3'b0, stall_id}, 4'b0001);
    chk("lu_stall.ex", ex_v, 4'b0100);
    step(6'd0, 5'd8, 5'd9, 1'b0);
    chk_all("lu_bubble", 4'b0000, 4'b1000, 4'b0100, 1'b0, 1'b0);
    step(6'd0, 5'd0, 5'd0, 1'b0);
    chk_all("lu_late_r", 4'b1010, 4'b0000, 4'b0110, 1'b0, 1'b0);
    // ex_rt = 0 never stalls
    step(6'd35, 5'd0, 5'd0, 1'b0);
    step(6'd0, 5'd0, 5'd0, 1'b0);
    chk("rt0.stall", {3'b0, stall_id}, 4'b0000);
    chk("rt0.ex", ex_v, 4'b0100);
    // ORI, BEQ, LW, then flush coinciding with a hazard on r7
    step(6'd13, 5'd1, 5'd2, 1'b0);
    step(6'd4, 5'd1, 5'd2, 1'b0);
    step(6'd35, 5'd1, 5'd7, 1'b0);
    step(6'd0, 5'd7, 5'd3, 1'b1);
    chk_all("fl_cycle", 4'b0100, 4'b0010, 4'b0100, 1'b0, 1'b0);
    step(6'd0, 5'd0, 5'd0, 1'b0);
    chk_all("fl_after", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    // unknown opcode 63
    step(6'd63, 5'd0, 5'd0, 1'b0);
    chk("ill63_id.ill", {3'b0, illegal_op}, 4'b0000);
    step(6'd0, 5'd0, 5'd0, 1'b0);
    chk("ill63_ex.ex", ex_v, 4'b0000);
    chk("ill63_ex.ill", {3'b0, illegal_op}, 4'b0001);
    step(6'd0, 5'd0, 5'd0, 1'b0);
    chk("ill63_next.ill", {3'b0, illegal_op}, 4'b0000);
    chk("ill63_next.ex", ex_v, 4'b1010);
    // opcode 3
    step(6'd3, 5'd0, 5'd0, 1'b0);
    step(6'd0, 5'd0, 5'd0, 1'b0);
    chk("op3_ex.ex", ex_v, 4'b0000);
`ifdef CTRL_JAL_EN
    chk("op3_ex.ill", {3'b0, illegal_op}, 4'b0000);
    step(6'd0, 5'd0, 5'd0, 1'b0);
    chk("op3_mem.mem", mem_v, 4'b0001);
    step(6'd0, 5'd0, 5'd0, 1'b0);
    chk("op3_wb.wb", wb_v, 4'b0101);
`else
    chk("op3_ex.ill", {3'b0, illegal_op}, 4'b0001);
    step(6'd0, 5'd0, 5'd0, 1'b0);
    chk("op3_mem.mem", mem_v, 4'b0000);
    step(6'd0, 5'd0, 5'd0, 1'b0);
    chk("op3_wb.wb", wb_v, 4'b0000);
`endif
    // async reset with LW/SW/R in flight
    step(6'd35, 5'd1, 5'd2, 1'b0);
    step(6'd43, 5'd1, 5'd3, 1'b0);
    step(6'd0, 5'd4, 5'd5, 1'b0);
    step(6'd0, 5'd4, 5'd5, 1'b0);
    chk_all("full_pipe", 4'b1010, 4'b0100, 4'b0110, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_all("async_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; opcode_id = 6'd0; rs_id = '0; rt_id = '0;
    #1;
    chk_all("rst_release", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step(6'd0, 5'd0, 5'd0, 1'b0);
    chk("restart.ex", ex_v, 4'b1010);
    chk("restart.mem", mem_v, 4'b0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_pipeline.md
CONTROL_PIPELINE -- requirements
Module: control_pipeline

Interface
REQ-001 SHALL have parameter OP_W, default 6: opcode width.
REQ-002 SHALL have parameter REG_ADDR_W, default 5: register-specifier width.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port opcode_id  in  OP_W: opcode of the instruction in ID.
REQ-006 SHALL have ports rs_id, rt_id  in  REG_ADDR_W: source specifiers in ID.
REQ-007 SHALL have port flush  in  1: taken branch or jump; squashes younger instructions.
REQ-008 SHALL have ports ex_RegDst, ex_ALUSrc  out  1, and ex_ALUOp  out  2: EX-stage controls.
REQ-009 SHALL have ports mem_MemRead, mem_MemWrite, mem_Branch, mem_Jump  out  1: MEM-stage controls.
REQ-010 SHALL have ports wb_RegWrite, wb_MemtoReg, wb_Link  out  1: WB-stage controls.
REQ-011 SHALL have port stall_id  out  1: load-use hazard; PC and IF/ID hold while high.
REQ-012 SHALL have port illegal_op  out  1: registered one-cycle pulse when an unknown opcode enters EX.

Function
REQ-013 SHALL decode per opcode:
- R (0): RegDst, RegWrite, ALUOp=10.
- LW (35): ALUSrc, MemtoReg, RegWrite, MemRead, ALUOp=00.
- SW (43): ALUSrc, MemWrite, ALUOp=00.
- BEQ (4): Branch, ALUOp=01.
- J (2): Jump only, ALUOp=00.
- ORI (13): ALUSrc, RegWrite, ALUOp=11.
All unlisted bits are 0; no X is ever driven.
REQ-014 SHALL decode an unknown opcode to all-zero controls (a bubble) and set illegal_op for that EX cycle.
REQ-015 SHALL hold three control registers, ID/EX, EX/MEM and MEM/WB, each with a valid bit.
REQ-016 SHALL present ex_* one cycle after opcode_id is sampled, mem_* after two cycles, and wb_* after three.
REQ-017 SHALL gate every output with its stage valid bit, so invalid stages drive 0.
REQ-018 SHALL latch rt_id into ID/EX as ex_rt.
REQ-019 SHALL assert stall_id combinationally when all of the following hold: ID/EX is valid, ex MemRead=1, ex_rt!=0, ex_rt equals rs_id or rt_id, and flush=0.
REQ-020 SHALL, while stall_id=1, load a bubble into ID/EX and advance EX/MEM and MEM/WB normally; the stalled instruction re-decodes in the next cycle.
REQ-021 SHALL, on flush=1, load bubbles into ID/EX and EX/MEM at the next edge while MEM/WB advances normally.
REQ-022 SHALL give flush priority when flush and a hazard coincide: stall_id=0 and bubbles per REQ-021.
REQ-023 SHALL stall on register 0 only if it is nonzero, so ex_rt=0 never stalls.

Reset
REQ-024 SHALL, on rst=1, immediately clear all valid bits, control registers, ex_rt and illegal_op regardless of clk.
REQ-025 SHALL drive every output to 0 during reset and in the first cycle after release.
REQ-026 SHALL discard any in-flight instruction when reset asserts mid-pipeline; no partial control survives.

Configuration
REQ-027 SHALL, with CTRL_JAL_EN defined, decode JAL (3) as RegWrite=1, Jump=1, Link=1, all else 0; wb_Link reaches WB with the instruction.
REQ-028 SHALL, without CTRL_JAL_EN, treat opcode 3 as illegal per REQ-014 and tie wb_Link to 0.

Structure
REQ-029 SHALL place opcode constants, ALUOp encodings and the packed control-bundle typedef in shared package control_pkg.
REQ-030 SHALL implement decoding in combinational sub-module control_decode, instantiated once in ID; the pipeline registers and hazard logic stay in control_pipeline.

Verification
REQ-031 SHALL cover: reset released, then opcode 0 every cycle -> ex_RegDst=1 and ex_ALUOp=10 at cycle 1; wb_RegWrite=1 from cycle 3.
REQ-032 SHALL cover: LW with rt=8 followed by R with rs=8 -> stall_id=1 for exactly one cycle, one bubble in EX, and the R controls reach EX one cycle late.
REQ-033 SHALL cover: LW with rt=0 followed by R with rs=0 -> stall_id stays 0.
REQ-034 SHALL cover: BEQ then flush=1 for one cycle while an LW load-use hazard is present -> stall_id=0, ex_* and mem_* zero the next cycle, and the older WB stage unaffected.
REQ-035 SHALL cover: opcode 63 -> all ex_* 0 and illegal_op=1 for one cycle; opcode 3 gives wb_Link=1 with CTRL_JAL_EN and illegal_op=1 without it.
REQ-036 SHALL cover: rst pulsed asynchronously mid-stream with three valid stages -> all outputs 0 before the next clk edge.
